// File: rtl/tcdm_dummy_memory_if.sv
// TCDM request/grant/r_valid bus, one instance per memory port.
// The master issues requests; the slave (memory) grants them and returns
// the response exactly one cycle after each grant.
interface hwpe_stream_intf_tcdm;

  // Request channel, driven by the master
  logic        req;
  logic [31:0] add;
  logic        wen;   // 1 = read, 0 = write
  logic [3:0]  be;
  logic [31:0] data;

  // Grant and response channel, driven by the slave
  logic        gnt;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/tcdm_dummy_memory.sv
// Multi-port byte-addressed behavioural memory acting as a TCDM slave.
// Every port is independent: a request is granted combinationally unless
// a registered pseudo-random stall is active for that port, and a granted
// request always completes with r_valid one cycle later. Reads sample the
// array before any same-edge write; when several ports write the same byte
// on one edge, the highest port index wins. Contents are never cleared by
// reset so a preload survives it. Per-port read/write counters are kept for
// bandwidth reporting.
module tcdm_dummy_memory #(
  parameter int unsigned MP          = 1,
  parameter int unsigned MEMORY_SIZE = 196608,
  parameter logic [31:0] BASE_ADDR   = 32'h0011_0000,
  parameter int unsigned PROB_STALL  = 0,
  // Clock period, application time and test time in ns; informational only
  parameter real         TCP         = 1.0,
  parameter real         TA          = 0.2,
  parameter real         TT          = 0.8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clk_delayed_i,
  input  logic                 randomize_i,
  input  logic                 enable_i,
  input  logic                 stallable_i,
  hwpe_stream_intf_tcdm.slave  tcdm [MP]
);

  // Index width of the byte array
  localparam int unsigned AW        = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEMORY_SIZE);
  localparam logic [31:0] PROB      = 32'(PROB_STALL);

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (maximal length)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Timing parameters and the delayed clock have no effect on the logic
  localparam real unused_timing = TCP + TA + TT;
  logic unused_clk_delayed;
  assign unused_clk_delayed = clk_delayed_i;

  // Distinct nonzero seed per port; the low half carries index+1
  function automatic logic [31:0] lfsr_seed(input int unsigned idx);
    return {16'hACE1, 16'(idx + 1)};
  endfunction

  // One Galois step of the stall LFSR
  function automatic logic [31:0] lfsr_step(input logic [31:0] value);
    return (value >> 1) ^ (value[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Hierarchically visible storage and bandwidth counters
  logic [7:0] memory [MEMORY_SIZE];
  int         cnt_rd [MP];
  int         cnt_wr [MP];

  // Flattened copy of the port array
  logic [MP-1:0] req;
  logic [MP-1:0] wen;
  logic [31:0]   add       [MP];
  logic [3:0]    be        [MP];
  logic [31:0]   data      [MP];

  // Per-port decode and handshake
  logic [MP-1:0] gnt;
  logic [MP-1:0] access;
  logic [MP-1:0] in_range;
  logic [MP-1:0] stall_draw;
  logic [31:0]   offset    [MP];
  logic [AW-1:0] base_idx  [MP];
  logic [31:0]   read_word [MP];
  logic [31:0]   r_data    [MP];

  // Registered state
  logic [MP-1:0] stall_q;
  logic [MP-1:0] r_valid_q;
  logic [31:0]   r_data_q  [MP];
  logic [31:0]   lfsr_q    [MP];

  for (genvar i = 0; i < MP; i++) begin : g_port
    assign req[i]          = tcdm[i].req;
    assign wen[i]          = tcdm[i].wen;
    assign add[i]          = tcdm[i].add;
    assign be[i]           = tcdm[i].be;
    assign data[i]         = tcdm[i].data;
    assign tcdm[i].gnt     = gnt[i];
    assign tcdm[i].r_valid = r_valid_q[i];
    assign tcdm[i].r_data  = r_data[i];
  end

  // Address decode, grant, stall draw, pre-write read word and response mux
  always_comb begin
    for (int i = 0; i < MP; i++) begin
      offset[i]     = (add[i] - BASE_ADDR) & 32'hFFFF_FFFC;
      in_range[i]   = (add[i] >= BASE_ADDR) && (offset[i] < MEM_BYTES);
      base_idx[i]   = offset[i][AW-1:0];
      gnt[i]        = req[i] & enable_i & ~stall_q[i];
      access[i]     = req[i] & gnt[i];
      stall_draw[i] = stallable_i && (PROB != 32'd0) &&
                      ((lfsr_q[i] % 32'd100) < PROB);
      read_word[i]  = 32'h0;
      if (in_range[i]) begin
        for (int b = 0; b < 4; b++) begin
          if ((offset[i] + 32'(b)) < MEM_BYTES) begin
            read_word[i][8*b +: 8] = memory[base_idx[i] + AW'(b)];
          end
        end
      end
      if (r_valid_q[i]) begin
        r_data[i] = r_data_q[i];
      end else if (randomize_i) begin
        r_data[i] = lfsr_q[i];
      end else begin
        r_data[i] = 32'h0;
      end
    end
  end

  // Per-port LFSR advance and registered stall decision for the next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MP; i++) begin
        lfsr_q[i] <= lfsr_seed(i);
      end
      stall_q <= '0;
    end else begin
      for (int i = 0; i < MP; i++) begin
        lfsr_q[i] <= lfsr_step(lfsr_q[i]);
      end
      stall_q <= stall_draw;
    end
  end

  // One-cycle response: read word for in-range reads, zero otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      for (int i = 0; i < MP; i++) begin
        r_data_q[i] <= 32'h0;
      end
    end else begin
      r_valid_q <= access;
      for (int i = 0; i < MP; i++) begin
        if (access[i] && wen[i] && in_range[i]) begin
          r_data_q[i] <= read_word[i];
        end else begin
          r_data_q[i] <= 32'h0;
        end
      end
    end
  end

  // Granted-access counters, wrapping at 32 bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MP; i++) begin
        cnt_rd[i] <= 0;
        cnt_wr[i] <= 0;
      end
    end else begin
      for (int i = 0; i < MP; i++) begin
        if (access[i]) begin
          if (wen[i]) begin
            cnt_rd[i] <= cnt_rd[i] + 1;
          end else begin
            cnt_wr[i] <= cnt_wr[i] + 1;
          end
        end
      end
    end
  end

  // Byte-enabled writes in ascending port order so the highest port wins;
  // a grant seen while reset is held is discarded like its response
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int i = 0; i < MP; i++) begin
        if (access[i] && !wen[i] && in_range[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (be[i][b] && ((offset[i] + 32'(b)) < MEM_BYTES)) begin
              memory[base_idx[i] + AW'(b)] <= data[i][8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_dummy_memory.sv
// Bench for tcdm_dummy_memory: randomized multi-port traffic against a byte
// array reference model, with a per-port expected-response queue drained by
// an independent monitor, plus directed boundary, stall and reset scenarios.
module tb_tcdm_dummy_memory;

  localparam int          NP         = 4;
  localparam int          MEMSZ      = 1024;
  localparam logic [31:0] BASE       = 32'h0011_0000;
  localparam int          PSTALL     = 50;
  localparam int          INIT_WORDS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic randomize_data = 1'b0;
  logic enable = 1'b0;
  logic stallable = 1'b0;
  logic clk_delayed = 1'b0;

  logic [NP-1:0] req_d;
  logic [NP-1:0] wen_d;
  logic [31:0]   add_d  [NP];
  logic [3:0]    be_d   [NP];
  logic [31:0]   data_d [NP];
  logic [NP-1:0] gnt_s;
  logic [NP-1:0] rvalid_s;
  logic [31:0]   rdata_s [NP];

  // Reference model state and scoreboard
  logic [7:0]  model_mem [MEMSZ];
  int          model_rd [NP];
  int          model_wr [NP];
  logic [31:0] exp_q [NP][$];
  int          grants [NP];
  int          valids [NP];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_tcdm tcdm_bus [NP] ();

  for (genvar g = 0; g < NP; g++) begin : g_bus
    assign tcdm_bus[g].req  = req_d[g];
    assign tcdm_bus[g].wen  = wen_d[g];
    assign tcdm_bus[g].add  = add_d[g];
    assign tcdm_bus[g].be   = be_d[g];
    assign tcdm_bus[g].data = data_d[g];
    assign gnt_s[g]         = tcdm_bus[g].gnt;
    assign rvalid_s[g]      = tcdm_bus[g].r_valid;
    assign rdata_s[g]       = tcdm_bus[g].r_data;
  end

  tcdm_dummy_memory #(
    .MP          (NP),
    .MEMORY_SIZE (MEMSZ),
    .BASE_ADDR   (BASE),
    .PROB_STALL  (PSTALL)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clk_delayed_i (clk_delayed),
    .randomize_i   (randomize_data),
    .enable_i      (enable),
    .stallable_i   (stallable),
    .tcdm          (tcdm_bus)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) & 32'hFFFF_FFFC;
    return (a >= BASE) && (off < 32'(MEMSZ));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int o;
    if (!model_in_range(a)) return 32'h0;
    o = int'((a - BASE) & 32'hFFFF_FFFC);
    return {model_mem[o+3], model_mem[o+2], model_mem[o+1], model_mem[o]};
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [3:0] be,
                                      input logic [31:0] d);
    int o;
    if (!model_in_range(a)) return;
    o = int'((a - BASE) & 32'hFFFF_FFFC);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model_mem[o+b] = d[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 85)
      return BASE + 32'($urandom_range(0, INIT_WORDS-1)) * 4 + 32'($urandom_range(0, 3));
    else if (r < 95)
      return BASE + 32'(MEMSZ) + 32'($urandom_range(0, 15)) * 4;
    else
      return BASE - 32'($urandom_range(1, 16)) * 4;
  endfunction

  task automatic idle_all();
    for (int i = 0; i < NP; i++) begin
      req_d[i]  = 1'b0;
      wen_d[i]  = 1'b1;
      add_d[i]  = 32'h0;
      be_d[i]   = 4'h0;
      data_d[i] = 32'h0;
    end
  endtask

  task automatic drive(input int p, input bit is_read, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    req_d[p]  = 1'b1;
    wen_d[p]  = is_read;
    add_d[p]  = a;
    be_d[p]   = be;
    data_d[p] = d;
  endtask

  // Called at a falling edge with the cycle's stimulus already set: checks
  // the grants, records expected responses, updates the model, then
  // advances to the next falling edge (or asserts reset just after the edge)
  task automatic apply_stimulus(input bit reset_mid = 1'b0);
    bit granted [NP];
    #1;
    for (int i = 0; i < NP; i++) begin
      if (!stallable)
        check_output($sformatf("gnt_p%0d", i), 32'(gnt_s[i]), 32'(req_d[i] & enable));
      else
        check_output($sformatf("gnt_unrequested_p%0d", i),
                     32'(gnt_s[i] & ~(req_d[i] & enable)), 32'd0);
      granted[i] = req_d[i] && gnt_s[i];
      if (granted[i]) begin
        grants[i]++;
        if (wen_d[i]) begin
          exp_q[i].push_back(model_read(add_d[i]));
          model_rd[i]++;
        end else begin
          exp_q[i].push_back(32'h0);
          model_wr[i]++;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (granted[i] && !wen_d[i]) model_write(add_d[i], be_d[i], data_d[i]);
    end
    if (reset_mid) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < NP; i++) begin
        exp_q[i].delete();
        model_rd[i] = 0;
        model_wr[i] = 0;
      end
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic expect_port0(input string name, input logic [31:0] word);
    check_output({name, "_valid"}, 32'(rvalid_s[0]), 32'd1);
    check_output({name, "_data"}, rdata_s[0], word);
  endtask

  task automatic check_counters(input string name);
    for (int i = 0; i < NP; i++) begin
      check_output($sformatf("%s_cnt_rd_p%0d", name, i), 32'(dut.cnt_rd[i]), 32'(model_rd[i]));
      check_output($sformatf("%s_cnt_wr_p%0d", name, i), 32'(dut.cnt_wr[i]), 32'(model_wr[i]));
    end
  endtask

  // Monitor: consumes one expected entry per r_valid, independently of stimulus
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NP; i++) begin
        if (rvalid_s[i]) begin
          valids[i]++;
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rvalid_p%0d: got r_valid=1, expected 0", i);
          end else begin
            check_output($sformatf("r_data_p%0d", i), rdata_s[i], exp_q[i].pop_front());
          end
        end else if (exp_q[i].size() != 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL missing_rvalid_p%0d: got r_valid=0, expected 1", i);
          exp_q[i].delete();
        end else if (!randomize_data) begin
          check_output($sformatf("idle_r_data_p%0d", i), rdata_s[i], 32'h0);
        end
      end
    end
  end

  initial begin
    int g0 [NP];
    int v0 [NP];
    int delta;
    for (int i = 0; i < NP; i++) begin
      model_rd[i] = 0;
      model_wr[i] = 0;
      grants[i]   = 0;
      valids[i]   = 0;
    end
    idle_all();

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      check_output($sformatf("reset_rvalid_p%0d", i), 32'(rvalid_s[i]), 32'd0);
      check_output($sformatf("reset_rdata_p%0d", i), rdata_s[i], 32'h0);
    end
    check_counters("reset");
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Fill the working region with random words, all ports in parallel
    for (int w = 0; w < INIT_WORDS; w += NP) begin
      for (int i = 0; i < NP; i++)
        drive(i, 1'b0, BASE + 32'((w + i) * 4), 4'hF, $urandom());
      apply_stimulus();
    end
    idle_all();

    // Preload word 0 and clear word 1, then read word 0 back
    drive(0, 1'b0, BASE, 4'hF, 32'h4433_2211);
    drive(1, 1'b0, BASE + 32'd4, 4'hF, 32'h0);
    apply_stimulus();
    idle_all();
    drive(0, 1'b1, BASE, 4'h0, 32'h0);
    apply_stimulus();
    expect_port0("read_word0", 32'h4433_2211);
    check_counters("after_first_read");

    // Partial write over zero, then read back
    idle_all();
    drive(0, 1'b0, BASE + 32'd4, 4'b0101, 32'hAABB_CCDD);
    apply_stimulus();
    expect_port0("partial_write_resp", 32'h0);
    idle_all();
    drive(0, 1'b1, BASE + 32'd4, 4'h0, 32'h0);
    apply_stimulus();
    expect_port0("partial_read", 32'h00BB_00DD);

    // Last valid word, then just past the end, then below the base
    idle_all();
    drive(0, 1'b0, BASE + 32'(MEMSZ - 4), 4'hF, 32'hCAFE_F00D);
    apply_stimulus();
    idle_all();
    drive(0, 1'b1, BASE + 32'(MEMSZ - 1), 4'h0, 32'h0);
    apply_stimulus();
    expect_port0("last_word", 32'hCAFE_F00D);
    idle_all();
    drive(0, 1'b1, BASE + 32'(MEMSZ), 4'h0, 32'h0);
    apply_stimulus();
    expect_port0("oor_read", 32'h0);
    idle_all();
    drive(0, 1'b0, BASE + 32'(MEMSZ), 4'hF, 32'hFFFF_FFFF);
    apply_stimulus();
    expect_port0("oor_write_resp", 32'h0);
    idle_all();
    drive(0, 1'b1, BASE - 32'd4, 4'h0, 32'h0);
    apply_stimulus();
    expect_port0("below_base_read", 32'h0);
    idle_all();
    drive(0, 1'b1, BASE, 4'h0, 32'h0);
    apply_stimulus();
    expect_port0("word0_after_oor_write", 32'h4433_2211);

    // Same-byte write collision: highest port wins
    idle_all();
    for (int i = 0; i < NP; i++) drive(i, 1'b0, BASE + 32'd8, 4'hF, 32'h1111_1111 * 32'(i + 1));
    apply_stimulus();
    idle_all();
    drive(0, 1'b1, BASE + 32'd8, 4'h0, 32'h0);
    apply_stimulus();
    expect_port0("collision", 32'h1111_1111 * 32'(NP));

    // Randomized mixed traffic with enable toggling
    for (int c = 0; c < 400; c++) begin
      enable         = ($urandom_range(0, 9) != 0);
      randomize_data = (c >= 200);
      for (int i = 0; i < NP; i++) begin
        req_d[i]  = ($urandom_range(0, 4) != 0);
        wen_d[i]  = 1'($urandom_range(0, 1));
        add_d[i]  = rand_addr();
        be_d[i]   = 4'($urandom_range(0, 15));
        data_d[i] = $urandom();
      end
      apply_stimulus();
    end
    enable         = 1'b1;
    randomize_data = 1'b0;
    check_counters("after_random");

    // Full load: every port reads every cycle
    for (int i = 0; i < NP; i++) begin
      g0[i] = grants[i];
      v0[i] = valids[i];
    end
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < NP; i++) drive(i, 1'b1, rand_addr(), 4'h0, 32'h0);
      apply_stimulus();
    end
    for (int i = 0; i < NP; i++)
      check_output($sformatf("full_load_rvalids_p%0d", i), 32'(valids[i] - v0[i]), 32'd100);
    check_counters("after_full_load");

    // Stalled traffic: grant ratio near the configured probability
    stallable = 1'b1;
    for (int i = 0; i < NP; i++) begin
      g0[i] = grants[i];
      v0[i] = valids[i];
    end
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NP; i++) drive(i, 1'b1, rand_addr(), 4'h0, 32'h0);
      apply_stimulus();
    end
    for (int i = 0; i < NP; i++) begin
      delta = grants[i] - g0[i];
      $display("[TB] stalled port %0d granted %0d of 1000", i, delta);
      check_output($sformatf("stall_grants_in_range_p%0d", i),
                   32'((delta >= 400) && (delta <= 600)), 32'd1);
      check_output($sformatf("stall_rvalids_eq_grants_p%0d", i),
                   32'(valids[i] - v0[i]), 32'(delta));
    end
    stallable = 1'b0;
    idle_all();
    apply_stimulus();

    // Stalls disabled: every cycle granted
    for (int i = 0; i < NP; i++) g0[i] = grants[i];
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < NP; i++) drive(i, 1'b1, rand_addr(), 4'h0, 32'h0);
      apply_stimulus();
    end
    for (int i = 0; i < NP; i++)
      check_output($sformatf("unstalled_grants_p%0d", i), 32'(grants[i] - g0[i]), 32'd1000);
    check_counters("after_stall");

    // Reset in the middle of a burst
    idle_all();
    drive(0, 1'b0, BASE, 4'hF, 32'h4433_2211);
    apply_stimulus();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NP; i++) drive(i, 1'b1, rand_addr(), 4'h0, 32'h0);
      apply_stimulus(c == 4);
    end
    idle_all();
    #1;
    for (int i = 0; i < NP; i++)
      check_output($sformatf("midreset_rvalid_p%0d", i), 32'(rvalid_s[i]), 32'd0);
    check_counters("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, BASE, 4'h0, 32'h0);
    apply_stimulus();
    expect_port0("preload_after_reset", 32'h4433_2211);
    check_counters("after_reset_read");

    // Drain and final accounting
    idle_all();
    apply_stimulus();
    apply_stimulus();
    for (int i = 0; i < NP; i++)
      check_output($sformatf("queue_empty_p%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
